// File: rtl/ps2_defs_pkg.sv
// rtl/ps2_defs_pkg.sv - PS/2 sender state encoding and frame constants
package ps2_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_HI = 2'd1,
    ST_SEND_LO = 2'd2,
    ST_GAP     = 2'd3
  } ps2_state_t;

  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Bits 1..10 of the frame (data LSB first, odd parity, stop); the start bit is driven on acceptance.
  function automatic logic [FRAME_BITS-2:0] build_payload(input logic [7:0] b);
    return {STOP_BIT, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_half_tick.sv
// rtl/ps2_half_tick.sv - half-period phase counter for the PS/2 clock
module ps2_half_tick #(
  parameter int HALF = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_tick
);

  localparam int CW = $clog2(HALF);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(HALF - 1));
  assign o_tick = i_run && w_wrap;

  // Held at zero while not running so every phase starts on a full half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_run || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_sender.sv
// rtl/ps2_sender.sv - device-to-host PS/2 frame transmitter
module ps2_sender
  import ps2_defs_pkg::*;
#(
  parameter int HALF = 8,
  parameter int GAP  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scancode,
  input  logic       valid,
  output logic       ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       done
);

  ps2_state_t              r_state;
  ps2_state_t              w_state_next;
  logic [FRAME_BITS-2:0]   r_frame;
  logic [3:0]              r_bit_cnt;
  logic [7:0]              r_gap_cnt;
  logic                    r_ps2_clk;
  logic                    r_ps2_data;
  logic                    w_data_next;
  logic                    w_tick;
  logic                    w_run;
  logic                    w_accept;
  logic                    w_last_bit;
  logic                    w_gap_end;
  logic                    w_advance;

  assign ready      = (r_state == ST_IDLE);
  assign w_accept   = valid && ready;
  assign w_run      = (r_state == ST_SEND_HI) || (r_state == ST_SEND_LO);
  assign w_last_bit = (r_bit_cnt == 4'(FRAME_BITS - 1));
  assign w_gap_end  = (r_state == ST_GAP) && (r_gap_cnt == 8'(GAP - 1));
  assign w_advance  = (r_state == ST_SEND_LO) && w_tick && !w_last_bit;
  assign done       = w_gap_end;
  assign ps2_clk    = r_ps2_clk;
  assign ps2_data   = r_ps2_data;

  ps2_half_tick #(.HALF(HALF)) u_half_tick (
    .clk    (clk),
    .rst    (rst),
    .i_run  (w_run),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_ps2_data;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_SEND_HI;
          w_data_next  = START_BIT;
        end
      end
      ST_SEND_HI: begin
        if (w_tick) w_state_next = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (w_tick) begin
          if (w_last_bit) begin
            w_state_next = ST_GAP;
            w_data_next  = 1'b1;
          end else begin
            w_state_next = ST_SEND_HI;
            w_data_next  = r_frame[0];
          end
        end
      end
      ST_GAP: begin
        if (w_gap_end) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Line registers are loaded from the next state so they move in lockstep with the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_frame    <= '1;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_ps2_clk  <= 1'b1;
      r_ps2_data <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_ps2_data <= w_data_next;
      r_ps2_clk  <= (w_state_next != ST_SEND_LO);
      if (w_accept) begin
        r_frame   <= build_payload(scancode);
        r_bit_cnt <= '0;
      end else if (w_advance) begin
        r_frame   <= {1'b1, r_frame[FRAME_BITS-2:1]};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (r_state == ST_GAP && !w_gap_end) begin
        r_gap_cnt <= r_gap_cnt + 8'd1;
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_sender.sv
// tb/tb_ps2_sender.sv - directed self-checking bench for ps2_sender (HALF=4, GAP=4)
module tb_ps2_sender;

  localparam int HALF = 4;
  localparam int GAP  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scancode = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  ps2_sender #(.HALF(HALF), .GAP(GAP)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .scancode (scancode),
    .valid    (valid),
    .ready    (ready),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Host-side receiver: samples ps2_data on each falling edge of ps2_clk.
  int          cyc = 0;
  int          m_n = 0;
  int          m_first = 0;
  int          fall_cnt = 0;
  int          stab_err = 0;
  logic        m_prev_clk = 1'b1;
  logic        m_prev_data = 1'b1;
  logic [10:0] m_bits = '0;
  logic [10:0] q_frame[$];
  int          q_first_fall[$];
  int          q_last_fall[$];
  int          q_done[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_n = 0;
      m_prev_clk = 1'b1;
      m_prev_data = 1'b1;
    end else begin
      if (m_prev_clk && !ps2_clk) begin
        fall_cnt++;
        if (m_n == 0) m_first = cyc;
        m_bits[m_n] = ps2_data;
        m_n++;
        if (m_n == 11) begin
          q_frame.push_back(m_bits);
          q_first_fall.push_back(m_first);
          q_last_fall.push_back(cyc);
          m_n = 0;
        end
      end
      if (!m_prev_clk && !ps2_clk && (ps2_data !== m_prev_data)) stab_err++;
      if (done) q_done.push_back(cyc);
      m_prev_clk = ps2_clk;
      m_prev_data = ps2_data;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    for (int k = 0; k < 400 && !ready; k++) step();
    scancode = b;
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    int n0;
    n0 = q_done.size();
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      if (q_done.size() > n0) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", ready); else n_pass++;
    n_checks++; if (ps2_clk !== 1'b1) $display("FAIL reset_clk got=%b want=1", ps2_clk); else n_pass++;
    n_checks++; if (ps2_data !== 1'b1) $display("FAIL reset_data got=%b want=1", ps2_data); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_frame_1c();
    bit got;
    int q0;
    int len;
    int dly;
    q0 = q_frame.size();
    send(8'h1C);
    // Valid while busy must be ignored.
    scancode = 8'hFF;
    valid = 1'b1;
    for (int i = 0; i < 40; i++) step();
    valid = 1'b0;
    wait_done(got);
    n_checks++; if (!got) $display("FAIL f1c_done_timeout got=0 want=1"); else n_pass++;
    step();
    n_checks++; if (ready !== 1'b1) $display("FAIL f1c_ready_after got=%b want=1", ready); else n_pass++;
    n_checks++; if (q_frame.size() != q0 + 1) $display("FAIL f1c_frame_count got=%0d want=%0d", q_frame.size() - q0, 1); else n_pass++;
    if (q_frame.size() > q0 && q_done.size() > 0) begin
      len = q_last_fall[$] - q_first_fall[$] + 2 * HALF;
      dly = q_done[$] - (q_last_fall[$] + HALF - 1);
      n_checks++; if (q_frame[$] !== 11'h438) $display("FAIL f1c_bits got=%h want=438", q_frame[$]); else n_pass++;
      n_checks++; if (len != 88) $display("FAIL f1c_frame_len got=%0d want=88", len); else n_pass++;
      n_checks++; if (dly != 4) $display("FAIL f1c_done_delay got=%0d want=4", dly); else n_pass++;
    end
    n_checks++; if (stab_err != 0) $display("FAIL f1c_low_phase_stable got=%0d want=0", stab_err); else n_pass++;
  endtask

  task automatic test_parity();
    logic [7:0]  bytes[2];
    logic [10:0] want[2];
    bit got;
    bytes[0] = 8'h00; want[0] = 11'h600;
    bytes[1] = 8'hF0; want[1] = 11'h7E0;
    for (int i = 0; i < 2; i++) begin
      send(bytes[i]);
      wait_done(got);
      n_checks++; if (!got) $display("FAIL par_done_timeout idx=%0d got=0 want=1", i); else n_pass++;
      if (q_frame.size() > 0) begin
        n_checks++; if (q_frame[$] !== want[i]) $display("FAIL par_frame idx=%0d got=%h want=%h", i, q_frame[$], want[i]); else n_pass++;
        n_checks++; if (q_frame[$][9] !== 1'b1) $display("FAIL par_bit idx=%0d got=%b want=1", i, q_frame[$][9]); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] want[4];
    int q0;
    int acc;
    bit will;
    want[0] = 11'h420; want[1] = 11'h622; want[2] = 11'h624; want[3] = 11'h426;
    for (int k = 0; k < 400 && !ready; k++) step();
    q0 = q_frame.size();
    acc = 0;
    scancode = 8'h10;
    valid = 1'b1;
    for (int i = 0; i < 2000 && acc < 4; i++) begin
      will = ready;
      step();
      if (will) begin
        acc++;
        scancode = scancode + 8'd1;
      end
    end
    valid = 1'b0;
    for (int i = 0; i < 400 && q_frame.size() < q0 + 4; i++) step();
    for (int i = 0; i < 30; i++) step();
    n_checks++; if (q_frame.size() != q0 + 4) $display("FAIL b2b_count got=%0d want=4", q_frame.size() - q0); else n_pass++;
    if (q_frame.size() >= q0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (q_frame[q0 + i] !== want[i]) $display("FAIL b2b_frame idx=%0d got=%h want=%h", i, q_frame[q0 + i], want[i]); else n_pass++;
      end
      // Frame period: 88 frame cycles + 4 gap cycles + 1 accepting idle cycle.
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (q_first_fall[q0 + i] - q_first_fall[q0 + i - 1] != 93)
          $display("FAIL b2b_spacing idx=%0d got=%0d want=93", i, q_first_fall[q0 + i] - q_first_fall[q0 + i - 1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    int q0;
    bit got;
    send(8'h1C);
    for (int i = 0; i < 400 && m_n < 5; i++) step();
    step();
    rst = 1'b1;
    #1;
    n_checks++; if (ps2_clk !== 1'b1) $display("FAIL rmid_clk got=%b want=1", ps2_clk); else n_pass++;
    n_checks++; if (ps2_data !== 1'b1) $display("FAIL rmid_data got=%b want=1", ps2_data); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL rmid_ready got=%b want=1", ready); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rmid_done got=%b want=0", done); else n_pass++;
    step();
    step();
    rst = 1'b0;
    f0 = fall_cnt;
    q0 = q_frame.size();
    for (int i = 0; i < 120; i++) step();
    n_checks++; if (fall_cnt != f0) $display("FAIL rmid_no_edges got=%0d want=0", fall_cnt - f0); else n_pass++;
    n_checks++; if (q_frame.size() != q0) $display("FAIL rmid_no_frame got=%0d want=0", q_frame.size() - q0); else n_pass++;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    scancode = 8'h5A;
    valid = 1'b1;
    step();
    valid = 1'b0;
    wait_done(got);
    n_checks++; if (!got) $display("FAIL rpost_done_timeout got=0 want=1"); else n_pass++;
    n_checks++; if (q_frame.size() != q0 + 1) $display("FAIL rpost_count got=%0d want=1", q_frame.size() - q0); else n_pass++;
    if (q_frame.size() > q0) begin
      n_checks++; if (q_frame[$] !== 11'h6B4) $display("FAIL rpost_frame got=%h want=6b4", q_frame[$]); else n_pass++;
    end
  endtask

  task automatic test_loopback();
    logic [7:0]  seq[3];
    logic [10:0] fr;
    logic [7:0]  rx;
    bit got;
    seq[0] = 8'h1C; seq[1] = 8'hF0; seq[2] = 8'h1C;
    for (int i = 0; i < 3; i++) begin
      send(seq[i]);
      wait_done(got);
      n_checks++; if (!got) $display("FAIL loop_done_timeout idx=%0d got=0 want=1", i); else n_pass++;
      if (q_frame.size() > 0) begin
        fr = q_frame[$];
        rx = fr[8:1];
        n_checks++; if (rx !== seq[i]) $display("FAIL loop_byte idx=%0d got=%h want=%h", i, rx, seq[i]); else n_pass++;
        n_checks++;
        if (fr[0] !== 1'b0 || fr[10] !== 1'b1 || fr[9] !== ~^rx)
          $display("FAIL loop_framing idx=%0d got=%h want_parity=%b", i, fr, ~^rx);
        else n_pass++;
      end
    end
    n_checks++; if (stab_err != 0) $display("FAIL loop_low_phase_stable got=%0d want=0", stab_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame_1c();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
